// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and leading-blank helper for the
// sequential binary-to-BCD converter (bin_to_bcd_seq).
package bcd_pkg;

  localparam int DIGITS     = 4;
  localparam int DIGIT_W    = 4;
  // One extra scratch digit catches the ten-thousands position for saturation.
  localparam int SCR_DIGITS = DIGITS + 1;
  localparam int SCR_W      = SCR_DIGITS * DIGIT_W;

  localparam int          MAX_DEC   = 9999;
  localparam logic [15:0] SAT_BCD   = 16'h9999;
  localparam logic [3:0]  BLANK_RST = 4'b1110;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Leading-zero blank mask, bit 3 = thousands; the ones digit always shows.
  function automatic logic [3:0] lead_blank(input logic [15:0] d);
    logic [3:0] m;
    m    = 4'b0000;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a scratch digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Add-3 correction when the digit would reach 10 or more after doubling.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Feeds the 4-digit multiplexed seven-segment display driver: the packed
// result is registered and announced by a one-cycle done pulse.
// Values above 9999 saturate to 16'h9999 with overflow set.
// Optional feature macro: BCD_LEADING_BLANK_EN adds the registered
// leading-zero blank mask output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             overflow
`ifdef BCD_LEADING_BLANK_EN
  ,
  output logic [3:0]       blank
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [WIDTH-1:0]       shreg_r;
  logic [SCR_W-1:0]       scratch_r;
  logic [SCR_W-1:0]       adj_s;
  logic [SCR_W+WIDTH-1:0] cat_s;
  logic [SCR_W-1:0]       scratch_nx_s;
  logic [WIDTH-1:0]       shreg_nx_s;
  logic                   load_s;
  logic                   shift_s;
  logic                   finish_s;
  logic [15:0]            res_bcd_s;
  logic                   res_ovf_s;
  logic                   busy_r;
  logic                   done_r;
  logic [15:0]            bcd_r;
  logic                   overflow_r;

  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch_r[g*DIGIT_W +: DIGIT_W]),
      .dout (adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected scratch and input bits shift left together as one long register.
  assign cat_s        = {adj_s, shreg_r} << 1;
  assign scratch_nx_s = cat_s[SCR_W+WIDTH-1:WIDTH];
  assign shreg_nx_s   = cat_s[WIDTH-1:0];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath control; start is only looked at while idle.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SHIFT;
          load_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_nx_s = IDLE;
          finish_s   = 1'b1;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Saturate when the final shift leaves anything in the ten-thousands digit.
  always_comb begin
    res_bcd_s = 16'h0000;
    res_ovf_s = 1'b0;
    if (scratch_nx_s[SCR_W-1:SCR_W-DIGIT_W] != 4'd0) begin
      res_bcd_s = SAT_BCD;
      res_ovf_s = 1'b1;
    end else begin
      res_bcd_s = scratch_nx_s[15:0];
      res_ovf_s = 1'b0;
    end
  end

  // Shift register, scratch digits and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      scratch_r <= {SCR_W{1'b0}};
    end else if (load_s) begin
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= bin;
      scratch_r <= {SCR_W{1'b0}};
    end else if (shift_s) begin
      cnt_r     <= cnt_r + CNT_W'(1);
      shreg_r   <= shreg_nx_s;
      scratch_r <= scratch_nx_s;
    end else begin
      cnt_r     <= cnt_r;
      shreg_r   <= shreg_r;
      scratch_r <= scratch_r;
    end
  end

  // Status flags; busy follows the next state so it rises on the accepted start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == SHIFT);
      done_r <= finish_s;
    end
  end

  // Result registers update only on the final shift, so no partial value shows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_r      <= 16'h0000;
      overflow_r <= 1'b0;
    end else if (finish_s) begin
      bcd_r      <= res_bcd_s;
      overflow_r <= res_ovf_s;
    end else begin
      bcd_r      <= bcd_r;
      overflow_r <= overflow_r;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign overflow = overflow_r;

`ifdef BCD_LEADING_BLANK_EN
  logic [3:0] blank_r;

  // Blank mask is registered alongside the digits it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_r <= BLANK_RST;
    end else if (finish_s) begin
      blank_r <= lead_blank(res_bcd_s);
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`endif

endmodule
